// File: rtl/fir_decim_engine.sv
// fir_decim_engine: TAP_NUM-tap signed FIR with AXI-Lite configuration and
// AXI-Stream data path. Supports programmable decimation, a zero-fill tail
// flush, sm_tlast on the final output and a stream-length error flag.
module fir_decim_engine #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned TAP_NUM     = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   awvalid,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   awready,
  input  logic                   wvalid,
  input  logic [pDATA_WIDTH-1:0] wdata,
  output logic                   wready,
  input  logic                   arvalid,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   arready,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  input  logic                   sm_tready
);
  localparam int unsigned IDX_W = (TAP_NUM > 1) ? $clog2(TAP_NUM) : 1;
  localparam int unsigned CW    = pDATA_WIDTH;
  localparam int unsigned TW    = pDATA_WIDTH + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_MAC  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]                    state, state_nxt;
  logic                          ap_idle, ap_done, err;
  logic [CW-1:0]                 len, decim;
  logic signed [pDATA_WIDTH-1:0] taps [TAP_NUM];
  logic signed [pDATA_WIDTH-1:0] xd   [TAP_NUM];
  logic signed [pDATA_WIDTH-1:0] acc;
  logic [IDX_W-1:0]              mac_idx, flush_cnt;
  logic [CW-1:0]                 beat_cnt, res_idx, dec_cnt;
  logic                          flush, flush_nxt, last_res;

  logic                          wr_en_c, rd_en_c, start_c, run_start_c;
  logic                          beat_c, beat_end_c, err_set_c, finish_c;
  logic                          mac_last_c, keep_c, last_kept_c;
  logic signed [pDATA_WIDTH-1:0] prod_c, sum_c;
  logic [CW-1:0]                 decim_eff_c, n_c;
  logic [TW-1:0]                 total_c;
  logic [pDATA_WIDTH-1:0]        rdata_c;
  logic                          wr_tap_hit_c;
  logic [IDX_W-1:0]              wr_tap_idx_c;

  assign wr_en_c     = awvalid && wvalid && awready;
  assign rd_en_c     = arvalid && arready;
  assign start_c     = wr_en_c && (awaddr == pADDR_WIDTH'(0)) && wdata[0] && ap_idle && (state == S_IDLE);
  assign run_start_c = start_c && (len != '0);
  assign beat_c      = ss_tvalid && ss_tready;
  assign beat_end_c  = ss_tlast || ((beat_cnt + CW'(1)) == len);
  assign err_set_c   = beat_c && (ss_tlast != ((beat_cnt + CW'(1)) == len));
  assign mac_last_c  = (mac_idx == IDX_W'(TAP_NUM - 1));
  assign keep_c      = (dec_cnt == '0);
  assign prod_c      = taps[mac_idx] * xd[mac_idx];
  assign sum_c       = acc + prod_c;
  assign decim_eff_c = (decim == '0) ? CW'(1) : decim;
  // Result count is known exactly once the input has ended; before that, len bounds it.
  assign n_c         = flush ? beat_cnt : len;
  assign total_c     = {1'b0, n_c} + TW'(TAP_NUM - 1);
  assign last_kept_c = ({1'b0, res_idx} + {1'b0, decim_eff_c}) >= total_c;
  assign finish_c    = ((state == S_MAC) && mac_last_c && !keep_c && last_res) ||
                       ((state == S_OUT) && sm_tready && last_res);

  // Tap address decode for writes
  always_comb begin
    wr_tap_hit_c = 1'b0;
    wr_tap_idx_c = '0;
    for (int k = 0; k < int'(TAP_NUM); k++) begin
      if (awaddr == pADDR_WIDTH'(32 + 4 * k)) begin
        wr_tap_hit_c = 1'b1;
        wr_tap_idx_c = IDX_W'(k);
      end
    end
  end

  // Register read mux; unmapped addresses read as zero
  always_comb begin
    rdata_c = '0;
    if (araddr == pADDR_WIDTH'(0))  rdata_c = pDATA_WIDTH'({err, ap_idle, ap_done, 1'b0});
    if (araddr == pADDR_WIDTH'(16)) rdata_c = len;
    if (araddr == pADDR_WIDTH'(20)) rdata_c = decim;
    for (int k = 0; k < int'(TAP_NUM); k++) begin
      if (araddr == pADDR_WIDTH'(32 + 4 * k)) rdata_c = taps[k];
    end
  end

  // FSM state register
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // FSM next state and flush-phase tracking
  always_comb begin
    state_nxt = state;
    flush_nxt = flush;
    case (state)
      S_IDLE: begin
        if (run_start_c) begin
          state_nxt = S_LOAD;
          flush_nxt = 1'b0;
        end
      end
      S_LOAD: begin
        if (flush) begin
          state_nxt = S_MAC;
        end else if (beat_c) begin
          state_nxt = S_MAC;
          if (beat_end_c) flush_nxt = 1'b1;
        end
      end
      S_MAC: begin
        if (mac_last_c) begin
          if (keep_c)        state_nxt = S_OUT;
          else if (last_res) state_nxt = S_IDLE;
          else               state_nxt = S_LOAD;
        end
      end
      S_OUT: begin
        if (sm_tready) state_nxt = last_res ? S_IDLE : S_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // AXI-Lite handshakes and read data capture
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      awready <= 1'b0;
      wready  <= 1'b0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
    end else begin
      awready <= awvalid && wvalid && !awready;
      wready  <= awvalid && wvalid && !awready;
      arready <= arvalid && !arready && !rvalid;
      if (rd_en_c) begin
        rvalid <= 1'b1;
        rdata  <= rdata_c;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  // Control/status and configuration registers; status sets win over clears
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      ap_idle <= 1'b1;
      ap_done <= 1'b0;
      err     <= 1'b0;
      len     <= '0;
      decim   <= CW'(1);
      for (int k = 0; k < int'(TAP_NUM); k++) taps[k] <= '0;
    end else begin
      if (rd_en_c && (araddr == pADDR_WIDTH'(0))) begin
        ap_done <= 1'b0;
        err     <= 1'b0;
      end
      if (start_c) begin
        ap_done <= (len == '0);
        ap_idle <= (len == '0);
        err     <= 1'b0;
      end
      if (err_set_c) err <= 1'b1;
      if (finish_c) begin
        ap_done <= 1'b1;
        ap_idle <= 1'b1;
      end
      if (wr_en_c && ap_idle) begin
        if (awaddr == pADDR_WIDTH'(16)) len   <= wdata;
        if (awaddr == pADDR_WIDTH'(20)) decim <= wdata;
        if (wr_tap_hit_c) taps[wr_tap_idx_c] <= wdata;
      end
    end
  end

  // Delay line, MAC accumulator, counters and stream outputs
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      for (int k = 0; k < int'(TAP_NUM); k++) xd[k] <= '0;
      acc       <= '0;
      mac_idx   <= '0;
      flush_cnt <= '0;
      beat_cnt  <= '0;
      res_idx   <= '0;
      dec_cnt   <= '0;
      flush     <= 1'b0;
      last_res  <= 1'b0;
      ss_tready <= 1'b0;
      sm_tvalid <= 1'b0;
      sm_tdata  <= '0;
      sm_tlast  <= 1'b0;
    end else begin
      flush     <= flush_nxt;
      ss_tready <= (state_nxt == S_LOAD) && !flush_nxt;
      case (state)
        S_IDLE: begin
          if (run_start_c) begin
            for (int k = 0; k < int'(TAP_NUM); k++) xd[k] <= '0;
            flush_cnt <= '0;
            beat_cnt  <= '0;
            res_idx   <= '0;
            dec_cnt   <= '0;
            last_res  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (flush || beat_c) begin
            for (int k = int'(TAP_NUM) - 1; k > 0; k--) xd[k] <= xd[k-1];
            xd[0]   <= flush ? '0 : ss_tdata;
            acc     <= '0;
            mac_idx <= '0;
            if (flush) begin
              flush_cnt <= flush_cnt + IDX_W'(1);
              last_res  <= (flush_cnt == IDX_W'(TAP_NUM - 2));
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
              last_res <= 1'b0;
            end
          end
        end
        S_MAC: begin
          acc     <= sum_c;
          mac_idx <= mac_idx + IDX_W'(1);
          if (mac_last_c) begin
            res_idx <= res_idx + CW'(1);
            dec_cnt <= (dec_cnt >= decim_eff_c - CW'(1)) ? '0 : dec_cnt + CW'(1);
            if (keep_c) begin
              sm_tvalid <= 1'b1;
              sm_tdata  <= sum_c;
              sm_tlast  <= last_kept_c;
            end
          end
        end
        S_OUT: begin
          if (sm_tready) begin
            sm_tvalid <= 1'b0;
            sm_tlast  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
